// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: cmd/rsp handshake in, one AXI
// write or read out, response held until consumed.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH    = 5,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_write,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDR_WIDTH-1:0]    araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_DATA, RSP
  } state_e;

  state_e                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [31:0]              rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;

  logic aw_hs, w_hs, aw_ok, w_ok;
  logic bump;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bump        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_write_d = cmd_write;
          awvalid_d   = cmd_write;
          wvalid_d    = cmd_write;
          arvalid_d   = ~cmd_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = cmd_write ? WR : RD;
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
          rsp_valid_d = 1'b1;
          bump        = (bresp != 2'b00);
          state_d     = RSP;
        end
      end
      RD: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          bump        = (rresp != 2'b00);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturate rather than wrap so a flood of errors stays visible.
    err_d = (bump && (err_q != '1)) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
      err_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign err_count = err_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = 4'hF;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = addr_q;
  assign arprot    = 3'b000;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master (initiator) that converts a simple command/response handshake into AXI4-Lite write or read transactions. It is the initiator side of the 5-bit-address register slaves in this design, such as the RGB LED controller. Typical drivers are a boot-time sequencer, a test harness, or a soft controller fabric block that must program those slaves without the PS. One transaction is in flight at a time; the response is returned on a held-valid response port.

## Interface
Parameters:
- ADDR_WIDTH, 5, AXI address width. Matches the register slaves' awaddr/araddr.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- aclk  in  1  clock. All logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  register byte address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp of the completed transaction.
- rsp_write  out  1  echo of cmd_write.
- err_count  out  ERR_CNT_WIDTH  count of responses with resp != 2'b00, saturating.
- awaddr  out  ADDR_WIDTH.
- awprot  out  3  constant 3'b000.
- awvalid  out  1.
- awready  in  1.
- wdata  out  32.
- wstrb  out  4  constant 4'hF.
- wvalid  out  1.
- wready  in  1.
- bresp  in  2.
- bvalid  in  1.
- bready  out  1.
- araddr  out  ADDR_WIDTH.
- arprot  out  3  constant 3'b000.
- arvalid  out  1.
- arready  in  1.
- rdata  in  32.
- rresp  in  2.
- rvalid  in  1.
- rready  out  1.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, latch addr/wdata/write, then go to WR or RD.
- WR
  - awvalid and wvalid are raised together and tracked independently by aw_done/w_done flags.
  - Each valid drops the cycle after its own handshake; neither is ever withdrawn before acceptance.
  - When both handshakes are complete (same or different cycles), go to WR_RESP.
- WR_RESP
  - bready = 1.
  - On bvalid, capture bresp and set rsp_rdata = 0, then go to RSP.
- RD
  - arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA
  - rready = 1.
  - On rvalid, capture rdata and rresp, then go to RSP.
- RSP
  - rsp_valid = 1, outputs stable.
  - On rsp_ready, go to IDLE.
- All AXI and rsp outputs are registered. awaddr/wdata/araddr hold the latched values for the whole transaction.
- err_count increments by 1 on each B or R handshake with resp != 2'b00. It saturates at all-ones and never wraps.
- No timeout: a missing slave response stalls the block in WR/WR_RESP/RD/RD_DATA indefinitely.

## Timing
- Reset values:
  - FSM = IDLE.
  - cmd_ready = 1 in the cycle after reset deassertion; 0 while areset is high.
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid = 0.
  - rsp_rdata, rsp_resp, rsp_write, err_count, awaddr, wdata, araddr = 0.
- Reset mid-transaction:
  - All valids drop on the next edge.
  - The in-flight transaction is abandoned and no response is produced.
  - The system must reset the slave together with this block.
- Command accepted at edge N: awvalid/wvalid (or arvalid) are high from N+1.
- Write, zero-wait slave:
  - aw/w handshake at N+1.
  - bready high from N+2; bvalid at N+2.
  - rsp_valid at N+3.
- Read, zero-wait slave:
  - ar handshake at N+1.
  - rready high from N+2; rvalid at N+2.
  - rsp_valid at N+3.
- Back-to-back throughput:
  - rsp_ready high at edge M returns the FSM to IDLE at M+1.
  - Next cmd accepted at M+1.
  - Peak rate is one command per 4 cycles.
- cmd_ready is 0 in every state except IDLE. A command held during busy is accepted only on return to IDLE.

## Test plan
- Write, zero wait: cmd write addr 0x04 data 0x0000_0007 -> awaddr=0x04, wdata=7, wstrb=F one cycle later; rsp_valid 3 cycles after acceptance with rsp_resp=0, rsp_rdata=0.
- Split write handshake: awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 6 cycles; bready asserted only after both handshakes; exactly one response.
- Read: slave returns rdata=0xDEAD_BEEF with a 3-cycle rvalid delay -> rsp_rdata=0xDEADBEEF, rsp_write=0; rready high throughout RD_DATA.
- Error counting: 3 transactions with SLVERR (2'b10) plus 1 OKAY -> err_count=3. Force ERR_CNT_WIDTH=2 and issue 5 errors -> err_count saturates at 3.
- Response backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp fields stable, cmd_ready=0, no new AXI activity; accept the next command the cycle after rsp_ready.
- Reset mid-write: assert areset while awvalid=1 -> all AXI valids and rsp_valid are 0 on the next edge, err_count=0, cmd_ready=1 the cycle after deassertion.
